somador_serial: RTL and testbench

SOMADOR_SERIAL -- requirements
Module: somador_serial

---
 rtl/somador_serial_pkg.sv | 18 +
 rtl/somador_completo.sv | 34 +++
 rtl/somador_serial.sv | 129 ++++++++++++
 tb/tb_somador_serial.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/somador_serial_pkg.sv
// -----------------------------------------------------------------------------
// somador_serial_pkg
// Shared definitions for the bit-serial adder:
//   - N_PADRAO : default operand width
//   - estado_t : FSM state encoding (2'b11 is unused and recovers to OCIOSO)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package somador_serial_pkg;

    localparam int N_PADRAO = 8;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        SOMANDO = 2'b01,
        FIM     = 2'b10
    } estado_t;

endpackage

// File: rtl/somador_completo.sv
// -----------------------------------------------------------------------------
// somador_completo
// Combinational one-bit full adder built from two half adders and an OR gate.
// Ports:
//   i_a, i_b  : operand bits
//   i_cin     : carry in
//   o_s       : sum bit
//   o_cout    : carry out
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module somador_completo (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    // First half adder: operand bits
    assign w_s1 = i_a ^ i_b;
    assign w_c1 = i_a & i_b;

    // Second half adder: partial sum with incoming carry
    assign o_s  = w_s1 ^ i_cin;
    assign w_c2 = w_s1 & i_cin;

    // Either half adder may generate the carry
    assign o_cout = w_c1 | w_c2;

endmodule

// File: rtl/somador_serial.sv
// -----------------------------------------------------------------------------
// somador_serial
// Bit-serial adder: adds two N-bit operands LSB first, one bit per clock,
// through a single full-adder stage with a registered carry.
// Ports:
//   clk      : clock, all state updates on the rising edge
//   rst_n    : synchronous active-low reset
//   inicio   : start request (accepted in OCIOSO or FIM)
//   a, b     : operands, captured only on an accepting edge
//   soma     : registered (a+b) mod 2^N, holds until the next completion
//   cout     : registered carry-out of a+b
//   ocupado  : high while an addition is in progress (SOMANDO)
//   pronto   : one-cycle pulse when soma/cout are updated (FIM)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module somador_serial
    import somador_serial_pkg::*;
#(
    parameter int N = N_PADRAO
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inicio,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] soma,
    output logic         cout,
    output logic         ocupado,
    output logic         pronto
);

    localparam int            CW       = $clog2(N);
    localparam logic [CW-1:0] CNT_ULT  = CW'(N - 1);
    localparam logic [CW-1:0] CNT_UM   = CW'(1);

    estado_t        r_estado;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_res;
    logic           r_carry;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_soma;
    logic           r_cout;
    logic           r_ocupado;
    logic           r_pronto;

    logic           w_s;
    logic           w_c;
    logic [N-1:0]   w_res_prox;

    somador_completo u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_c)
    );

    // New sum bit enters at the MSB so after N shifts bit 0 is the first LSB
    assign w_res_prox = {w_s, r_res[N-1:1]};

    // FSM, datapath shifting and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado  <= OCIOSO;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_soma    <= '0;
            r_cout    <= 1'b0;
            r_ocupado <= 1'b0;
            r_pronto  <= 1'b0;
        end else begin
            case (r_estado)
                OCIOSO, FIM: begin
                    if (inicio) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_res     <= '0;
                        r_carry   <= 1'b0;
                        r_cnt     <= '0;
                        r_estado  <= SOMANDO;
                        r_ocupado <= 1'b1;
                        r_pronto  <= 1'b0;
                    end else begin
                        r_estado  <= OCIOSO;
                        r_ocupado <= 1'b0;
                        r_pronto  <= 1'b0;
                    end
                end
                SOMANDO: begin
                    r_res   <= w_res_prox;
                    r_carry <= w_c;
                    r_a     <= {1'b0, r_a[N-1:1]};
                    r_b     <= {1'b0, r_b[N-1:1]};
                    r_cnt   <= r_cnt + CNT_UM;
                    if (r_cnt == CNT_ULT) begin
                        // Last bit: publish the completed result
                        r_soma    <= w_res_prox;
                        r_cout    <= w_c;
                        r_estado  <= FIM;
                        r_ocupado <= 1'b0;
                        r_pronto  <= 1'b1;
                    end else begin
                        r_estado  <= SOMANDO;
                        r_ocupado <= 1'b1;
                        r_pronto  <= 1'b0;
                    end
                end
                default: begin
                    // Unused encoding: fall back to idle without touching results
                    r_estado  <= OCIOSO;
                    r_carry   <= 1'b0;
                    r_cnt     <= '0;
                    r_ocupado <= 1'b0;
                    r_pronto  <= 1'b0;
                end
            endcase
        end
    end

    assign soma    = r_soma;
    assign cout    = r_cout;
    assign ocupado = r_ocupado;
    assign pronto  = r_pronto;

endmodule

// File: tb/tb_somador_serial.sv
`timescale 1ns/1ps
module tb_somador_serial;

    localparam int N     = 8;
    localparam int LANES = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inicio;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [N-1:0] soma;
    logic         cout;
    logic         ocupado;
    logic         pronto;

    // Sweep lanes: several instances in lockstep cover all operand pairs
    logic                      sw_inicio;
    logic [LANES-1:0][N-1:0]   sw_a;
    logic [LANES-1:0][N-1:0]   sw_b;
    logic [LANES-1:0][N-1:0]   sw_soma;
    logic [LANES-1:0]          sw_cout;
    logic [LANES-1:0]          sw_ocup;
    logic [LANES-1:0]          sw_pronto;

    int n_comp = 0;
    int n_erro = 0;
    logic [31:0] ultimo = 32'd0;   // last completed {cout,soma} expected

    always #5 clk = ~clk;

    somador_serial #(.N(N)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inicio  (inicio),
        .a       (op_a),
        .b       (op_b),
        .soma    (soma),
        .cout    (cout),
        .ocupado (ocupado),
        .pronto  (pronto)
    );

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            somador_serial #(.N(N)) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .inicio  (sw_inicio),
                .a       (sw_a[g]),
                .b       (sw_b[g]),
                .soma    (sw_soma[g]),
                .cout    (sw_cout[g]),
                .ocupado (sw_ocup[g]),
                .pronto  (sw_pronto[g])
            );
        end
    endgenerate

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_comp++;
        if (obs !== esp) begin
            n_erro++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
        end
    endtask

    // Reference: plain arithmetic, N+1 bits
    function automatic logic [31:0] ref_soma(input logic [N-1:0] x, input logic [N-1:0] y);
        int s;
        s = int'(x) + int'(y);
        return 32'(s);
    endfunction

    task automatic inicia(input logic [N-1:0] x, input logic [N-1:0] y);
        op_a   = x;
        op_b   = y;
        inicio = 1'b1;
    endtask

    // One cycle mid-run: must be busy and still show the previous result
    task automatic passo(input string tag);
        @(negedge clk);
        verifica({tag, "/ocupado"}, 32'(ocupado), 32'd1);
        verifica({tag, "/hold"}, {23'd0, cout, soma}, ultimo);
    endtask

    // Wait for pronto; checks latency, busy cycles, held value and result
    task automatic espera_fim(input string tag, input logic [31:0] esp,
                              input int ciclos_esp, input bit perturba);
        int  ciclos = 0;
        int  ocup   = 0;
        bit  visto  = 1'b0;
        for (int i = 0; i < 4 * N; i++) begin
            @(negedge clk);
            ciclos++;
            if (pronto) begin
                visto = 1'b1;
                break;
            end
            if (ocupado) ocup++;
            verifica({tag, "/hold"}, {23'd0, cout, soma}, ultimo);
            if (perturba) begin
                op_a   = 8'($urandom);
                op_b   = 8'($urandom);
                inicio = 1'($urandom);
            end
        end
        verifica({tag, "/pronto"}, 32'(visto), 32'd1);
        verifica({tag, "/soma"}, {23'd0, cout, soma}, esp);
        verifica({tag, "/ciclos"}, 32'(ciclos), 32'(ciclos_esp));
        verifica({tag, "/ocupado"}, 32'(ocup), 32'(ciclos_esp - 1));
        ultimo = esp;
    endtask

    // Drop inicio in FIM: pronto must end after one cycle, result held
    task automatic libera(input string tag);
        inicio = 1'b0;
        @(negedge clk);
        verifica({tag, "/pulso"}, {30'd0, pronto, ocupado}, 32'd0);
        verifica({tag, "/mantem"}, {23'd0, cout, soma}, ultimo);
    endtask

    task automatic varredura();
        bit ok;
        logic [15:0] p;
        for (int l = 0; l < LANES; l++) begin
            p = 16'(l);
            sw_a[l] = p[15:8];
            sw_b[l] = p[7:0];
        end
        sw_inicio = 1'b1;
        for (int k = 0; k < 65536 / LANES; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 3 * N; i++) begin
                @(negedge clk);
                if (sw_pronto[0]) begin
                    ok = 1'b1;
                    break;
                end
            end
            verifica("varredura/pronto", {16'd0, sw_pronto}, {16'd0, {LANES{ok}}} | 32'hFFFF);
            if (!ok) begin
                verifica("varredura/timeout", 32'd0, 32'd1);
                break;
            end
            for (int l = 0; l < LANES; l++) begin
                p = 16'(k * LANES + l);
                verifica("varredura/soma", {23'd0, sw_cout[l], sw_soma[l]},
                         ref_soma(p[15:8], p[7:0]));
            end
            if (k < 65536 / LANES - 1) begin
                for (int l = 0; l < LANES; l++) begin
                    p = 16'((k + 1) * LANES + l);
                    sw_a[l] = p[15:8];
                    sw_b[l] = p[7:0];
                end
            end else begin
                sw_inicio = 1'b0;
            end
        end
    endtask

    initial begin
        bit viu;
        logic [N-1:0] ra, rb;
        rst_n     = 1'b0;
        inicio    = 1'b0;
        op_a      = '0;
        op_b      = '0;
        sw_inicio = 1'b0;
        sw_a      = '0;
        sw_b      = '0;

        // Reset, with inicio asserted to show reset wins
        @(negedge clk);
        inicio = 1'b1;
        repeat (2) @(negedge clk);
        verifica("reset/soma", {24'd0, soma}, 32'd0);
        verifica("reset/cout", 32'(cout), 32'd0);
        verifica("reset/flags", {30'd0, ocupado, pronto}, 32'd0);
        inicio = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        verifica("reset/ocioso", {30'd0, ocupado, pronto}, 32'd0);

        // Zero operands
        inicia(8'h00, 8'h00);
        espera_fim("z00", ref_soma(8'h00, 8'h00), N + 1, 1'b0);
        libera("z00");

        // Full carry propagation
        inicia(8'hFF, 8'h01);
        espera_fim("ff01", 32'h100, N + 1, 1'b0);
        libera("ff01");

        // Back-to-back in FIM
        inicia(8'hA5, 8'h5A);
        espera_fim("a55a", 32'h0FF, N + 1, 1'b0);
        inicia(8'h80, 8'h80);
        espera_fim("b2b", 32'h100, N + 1, 1'b0);
        libera("b2b");

        // inicio and new operands during SOMANDO are ignored
        inicia(8'h3C, 8'h0F);
        passo("ign1");
        inicio = 1'b0;
        passo("ign2");
        passo("ign3");
        inicia(8'hFF, 8'hFF);
        espera_fim("ign", 32'h04B, N + 1 - 3, 1'b0);
        libera("ign");

        // Reset mid-addition aborts, no pronto afterwards
        inicia(8'h7F, 8'h7F);
        passo("abort1");
        inicio = 1'b0;
        passo("abort2");
        passo("abort3");
        rst_n = 1'b0;
        @(negedge clk);
        verifica("abort/saidas", {21'd0, ocupado, pronto, cout, soma}, 32'd0);
        ultimo = 32'd0;
        rst_n  = 1'b1;
        viu    = 1'b0;
        repeat (2 * N) begin
            @(negedge clk);
            if (pronto || ocupado) viu = 1'b1;
        end
        verifica("abort/sem_pronto", 32'(viu), 32'd0);
        inicia(8'h7F, 8'h7F);
        espera_fim("refaz", 32'h0FE, N + 1, 1'b0);
        libera("refaz");

        // Random operations, random chaining, inputs perturbed while busy
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            inicia(ra, rb);
            espera_fim("rand", ref_soma(ra, rb), N + 1, 1'b1);
            if ($urandom_range(0, 1) == 0) libera("rand");
        end
        libera("rand_fim");

        // Exhaustive operand sweep
        varredura();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_erro);
        $finish;
    end

endmodule
